// File: rtl/rr_stage_pkg.sv
// Shared types and constants for the register-read stage and its register file.
package rr_stage_pkg;

    localparam int unsigned NREGS = 32;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned REGW  = $clog2(NREGS);

    typedef logic [REGW-1:0] reg_t;
    typedef logic [XLEN-1:0] bus64_t;

    typedef struct packed {
        logic   valid;
        reg_t   rs1;
        reg_t   rs2;
        reg_t   rd;
        bus64_t data_rs1;
        bus64_t data_rs2;
    } rr_exe_instr_t;

endpackage

// File: rtl/rr_stage_regfile.sv
// Integer register file: two combinational read ports, one write port, x0 hardwired to zero.
// RR_WRITE_THROUGH_EN forwards the same-cycle write data onto matching read ports.
module rr_stage_regfile
    import rr_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  reg_t   rd_addr_a,
    output bus64_t rd_data_a,
    input  reg_t   rd_addr_b,
    output bus64_t rd_data_b,
    input  logic   wr_en,
    input  reg_t   wr_addr,
    input  bus64_t wr_data
);

    bus64_t mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
        rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];
`ifdef RR_WRITE_THROUGH_EN
        if (wr_en && wr_addr != '0 && wr_addr == rd_addr_a) rd_data_a = wr_data;
        if (wr_en && wr_addr != '0 && wr_addr == rd_addr_b) rd_data_b = wr_data;
`endif
    end

endmodule

// File: rtl/rr_stage.sv
// Register-read stage: register file, long-latency busy scoreboard and dec->exe pipeline register.
// Optional macro RR_WRITE_THROUGH_EN: same-cycle write-back resolves a busy source without a bubble.
module rr_stage
    import rr_stage_pkg::*;
(
    input  logic   clk_i,
    input  logic   rstn_i,
    input  logic   dec_valid_i,
    input  reg_t   dec_rs1_i,
    input  reg_t   dec_rs2_i,
    input  reg_t   dec_rd_i,
    input  logic   dec_we_i,
    input  logic   dec_long_i,
    output logic   dec_ready_o,
    input  logic   stall_i,
    input  logic   flush_i,
    input  logic   wb_valid_i,
    input  reg_t   wb_rd_i,
    input  bus64_t wb_data_i,
    output logic   rr_valid_o,
    output reg_t   rr_rs1_o,
    output reg_t   rr_rs2_o,
    output reg_t   rr_rd_o,
    output bus64_t rr_data_rs1_o,
    output bus64_t rr_data_rs2_o,
    output logic   hazard_o
);

    bus64_t             data_rs1;
    bus64_t             data_rs2;
    logic [NREGS-1:0]   busy;
    logic [NREGS-1:0]   busy_next;
    rr_exe_instr_t      pipe;
    logic               hazard;
    logic               ready;

    rr_stage_regfile u_regfile (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .rd_addr_a (dec_rs1_i),
        .rd_data_a (data_rs1),
        .rd_addr_b (dec_rs2_i),
        .rd_data_b (data_rs2),
        .wr_en     (wb_valid_i),
        .wr_addr   (wb_rd_i),
        .wr_data   (wb_data_i)
    );

    function automatic logic src_busy(input reg_t rs);
        logic b;
        b = (rs != '0) && busy[rs];
`ifdef RR_WRITE_THROUGH_EN
        if (wb_valid_i && wb_rd_i == rs) b = 1'b0;
`endif
        return b;
    endfunction

    // Gated by reset so both handshake outputs read 0 while reset is asserted.
    always_comb begin
        hazard = rstn_i && dec_valid_i && (src_busy(dec_rs1_i) || src_busy(dec_rs2_i));
        ready  = rstn_i && dec_valid_i && !stall_i && !hazard && !flush_i;
    end

    assign hazard_o    = hazard;
    assign dec_ready_o = ready;

    // Set after clear so a same-cycle long accept on the write-back index stays busy.
    always_comb begin
        busy_next = busy;
        if (wb_valid_i) busy_next[wb_rd_i] = 1'b0;
        if (ready && dec_we_i && dec_long_i && dec_rd_i != '0) busy_next[dec_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy <= '0;
        end else if (flush_i) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pipe <= '0;
        end else if (flush_i) begin
            pipe.valid <= 1'b0;
        end else if (stall_i) begin
            if (wb_valid_i && wb_rd_i != '0) begin
                if (wb_rd_i == pipe.rs1) pipe.data_rs1 <= wb_data_i;
                if (wb_rd_i == pipe.rs2) pipe.data_rs2 <= wb_data_i;
            end
        end else if (!ready) begin
            pipe.valid <= 1'b0;
        end else begin
            pipe.valid    <= 1'b1;
            pipe.rs1      <= dec_rs1_i;
            pipe.rs2      <= dec_rs2_i;
            pipe.rd       <= dec_rd_i;
            pipe.data_rs1 <= data_rs1;
            pipe.data_rs2 <= data_rs2;
        end
    end

    assign rr_valid_o    = pipe.valid;
    assign rr_rs1_o      = pipe.rs1;
    assign rr_rs2_o      = pipe.rs2;
    assign rr_rd_o       = pipe.rd;
    assign rr_data_rs1_o = pipe.data_rs1;
    assign rr_data_rs2_o = pipe.data_rs2;

endmodule
